// File: rtl/float_cvt_bf16_to_e4m3.sv
// Two-stage bf16 -> e4m3 narrowing converter: RNE rounding, saturating overflow.
// Optional sticky status port (inexact/overflow/underflow) under `FLOAT_CVT_STATUS_EN.
module float_cvt_bf16_to_e4m3 #(
  parameter int E4M3_BIAS = 7,
  parameter int BF16_BIAS = 127
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
`ifdef FLOAT_CVT_STATUS_EN
  ,
  output logic [2:0]  status,
  input  logic        status_clr
`endif
);

  localparam int STAGES = 2;

  typedef enum logic [2:0] {C_ZERO, C_NORM, C_SUB, C_SAT, C_NAN} cls_e;

  typedef struct packed {
    logic       s;
    cls_e       cls;
    logic [9:0] ee;
    logic [7:0] sig8;
    logic [3:0] shift;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  logic            advance;

  assign out_valid = vld_pipe[2];
  assign advance   = !vld_pipe[2] || out_ready;
  assign in_ready  = !reset && (!vld_pipe[1] || advance);

  // ---------------- stage 1: unpack / classify ----------------
  logic [7:0]        e_in;
  logic [6:0]        m_in;
  logic signed [9:0] ee_in;
  logic signed [9:0] sh_raw;

  assign e_in = in_data[14:7];
  assign m_in = in_data[6:0];

  always_comb begin
    ee_in  = $signed({2'b00, e_in}) - 10'sd120;
    sh_raw = 10'sd5 - ee_in;
    s1_d       = '0;
    s1_d.s     = in_data[15];
    s1_d.ee    = ee_in;
    s1_d.sig8  = {1'b1, m_in};
    if (e_in == 8'h00)      s1_d.cls = C_ZERO;
    else if (e_in == 8'hFF) s1_d.cls = (m_in == 7'h00) ? C_SAT : C_NAN;
    else if (ee_in > 10'sd15) s1_d.cls = C_SAT;
    else if (ee_in > 10'sd0)  s1_d.cls = C_NORM;
    else                      s1_d.cls = C_SUB;
    // Beyond 10 every significand bit is already below the guard position.
    if (s1_d.cls == C_SUB)
      s1_d.shift = (sh_raw > 10'sd10) ? 4'd10 : sh_raw[3:0];
  end

  // ---------------- stage 2: round / pack ----------------
  logic [17:0] wide;
  logic [6:0]  em;
  logic        g, st, rnd, sat_rnd;
  logic [7:0]  sum;
  logic [6:0]  mag;
  logic [2:0]  flags;
  logic        inexact, src_nz;

  always_comb begin
    wide    = {s1_q.sig8, 10'b0} >> s1_q.shift;
    em      = {4'b0, wide[12:10]};
    g       = wide[9];
    st      = |wide[8:0];
    if (s1_q.cls == C_NORM) begin
      em = {s1_q.ee[3:0], s1_q.sig8[6:4]};
      g  = s1_q.sig8[3];
      st = |s1_q.sig8[2:0];
    end
    // Rounding acts on {exp,man} so mantissa carry walks into the exponent.
    rnd     = g && (st || em[0]);
    sum     = {1'b0, em} + {7'b0, rnd};
    sat_rnd = (sum >= 8'h7F);
    inexact = g || st;
    src_nz  = |s1_q.sig8[6:0];
    mag     = sat_rnd ? 7'h7E : sum[6:0];
    flags   = '0;
    case (s1_q.cls)
      C_ZERO: begin
        mag   = 7'h00;
        flags = {src_nz, 1'b0, src_nz};
      end
      C_SAT: begin
        mag   = 7'h7E;
        // ee of 135 only comes from E==255, i.e. infinity, which is not inexact.
        flags = {1'b0, 1'b1, (s1_q.ee != 10'd135)};
      end
      C_NAN:  mag = 7'h7F;
      C_NORM: flags = {1'b0, sat_rnd, inexact};
      C_SUB:  flags = {inexact && (mag[6:3] == 4'h0), sat_rnd, inexact};
      default: mag = 7'h7F;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out_data <= 8'h00;
    end else begin
      if (advance) vld_pipe[2] <= vld_pipe[1];
      if (advance && vld_pipe[1]) out_data <= {s1_q.s, mag};
      if (in_ready) vld_pipe[1] <= in_valid;
      if (in_ready && in_valid) s1_q <= s1_d;
    end
  end

`ifdef FLOAT_CVT_STATUS_EN
  logic [2:0] out_flags;
  logic       unused_bits;

  assign unused_bits = ^wide[17:13];

  always_ff @(posedge clock) begin
    if (reset) begin
      out_flags <= '0;
      status    <= '0;
    end else begin
      if (advance && vld_pipe[1]) out_flags <= flags;
      // Set wins over clear: a same-edge transfer's flags survive status_clr.
      status <= (status_clr ? 3'b000 : status) |
                ((out_valid && out_ready) ? out_flags : 3'b000);
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{wide[17:13], flags, s1_q.ee[9:4]};
`endif

endmodule
